dt_pipe_eval: RTL

- Parametrised, pipelined, run-time-programmable binary decision-tree classifier. It generalises the fixed combinational per-benchmark tree blocks.
- Evaluates one full-depth tree of DEPTH levels over an IN_W-bit feature vector and returns an OUT_W-bit leaf code, typically a thermometer class code.
- Node and leaf tables are loaded through a config port, so one instance serves every benchmark.
- Sits between the feature-extraction stage and the result collector, with valid/ready on both sides.

---
 rtl/dt_pipe_eval_if.sv | 37 +++
 rtl/dt_pipe_eval.sv | 130 +++++++++++++
 2 files changed

// File: rtl/dt_pipe_eval_if.sv
// Handshake and configuration bundle for dt_pipe_eval.
//   in_valid/in_ready/inp        : sample input side
//   out_valid/out_ready/outp/
//   out_leaf                     : classification result side
//   cfg_we/cfg_sel/cfg_addr/
//   cfg_data                     : node/leaf table write port
// master = producer/consumer/configurator side, slave = classifier side.
interface dt_pipe_eval_if #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 6,
  parameter int DEPTH = 4
);
  localparam int FW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int CW = ((FW + 1) > OUT_W) ? (FW + 1) : OUT_W;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  inp;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] outp;
  logic [DEPTH-1:0] out_leaf;
  logic             cfg_we;
  logic             cfg_sel;
  logic [DEPTH-1:0] cfg_addr;
  logic [CW-1:0]    cfg_data;

  modport master (
    output in_valid, inp, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_data,
    input  in_ready, out_valid, outp, out_leaf
  );

  modport slave (
    input  in_valid, inp, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_data,
    output in_ready, out_valid, outp, out_leaf
  );
endinterface

// File: rtl/dt_pipe_eval.sv
// Pipelined, run-time-programmable binary decision-tree classifier.
// One pipeline stage per tree level; the last stage also registers the
// leaf code. Node entries are {pol, feat}: direction = inp[feat] ^ pol
// (feature bits at or above IN_W read as 0). Node table is heap-ordered.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : dt_pipe_eval_if.slave (sample in, result out, table config)
module dt_pipe_eval #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 6,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dt_pipe_eval_if.slave  bus
);
  localparam int FW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int NN = (1 << DEPTH) - 1;
  localparam int NL = 1 << DEPTH;
  localparam int FP = 1 << FW;

  // Tables
  logic [FW:0]      node_q [NN];
  logic [OUT_W-1:0] leaf_q [NL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NN; i++) node_q[i] <= '0;
      for (int unsigned i = 0; i < NL; i++) leaf_q[i] <= '0;
    end else if (bus.cfg_we) begin
      if (bus.cfg_sel) begin
        leaf_q[bus.cfg_addr] <= bus.cfg_data[OUT_W-1:0];
      end else if (int'(bus.cfg_addr) < NN) begin
        node_q[bus.cfg_addr] <= bus.cfg_data[FW:0];
      end
    end
  end

  // Pipeline state: stage k holds the path after evaluating levels 0..k
  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0][DEPTH-1:0] p_q;
  logic [OUT_W-1:0]            outp_q;

  logic [DEPTH-1:0]            rdy;
  logic [DEPTH-1:0]            src_vld;
  logic [DEPTH-1:0]            dir;
  logic [DEPTH-1:0][DEPTH-1:0] src_p;
  logic [DEPTH-1:0][DEPTH-1:0] nxt_p;
  logic [DEPTH-1:0][DEPTH-1:0] node_addr;
  logic [DEPTH-1:0][FW:0]      node_ent;
  logic [DEPTH-1:0][FP-1:0]    fvec;
  logic [DEPTH-1:0][IN_W-1:0]  src_samp;

  // The last stage never needs the sample, so only DEPTH-1 copies are kept.
  assign src_samp[0] = bus.inp;

  if (DEPTH > 1) begin : g_samp
    logic [DEPTH-2:0][IN_W-1:0] samp_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        samp_q <= '0;
      end else begin
        for (int unsigned k = 0; k < DEPTH - 1; k++) begin
          if (rdy[k] && src_vld[k]) samp_q[k] <= src_samp[k];
        end
      end
    end

    for (genvar g = 1; g < DEPTH; g++) begin : g_src
      assign src_samp[g] = samp_q[g-1];
    end
  end

  // ready_k = !valid_k || ready_{k+1} unrolled: stage k is ready unless it
  // and every stage after it are full while the sink is stalled.
  always_comb begin
    rdy = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      rdy[k] = bus.out_ready || ((vld_q | DEPTH'((1 << k) - 1)) != '1);
    end
  end

  always_comb begin
    src_vld   = '0;
    src_p     = '0;
    nxt_p     = '0;
    dir       = '0;
    node_addr = '0;
    node_ent  = '0;
    fvec      = '0;
    src_vld[0] = bus.in_valid;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      src_vld[k] = vld_q[k-1];
      src_p[k]   = p_q[k-1];
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      node_addr[k] = DEPTH'((1 << k) - 1) + src_p[k];
      node_ent[k]  = node_q[node_addr[k]];
      // Zero-padding to a power of two makes out-of-range features read 0.
      fvec[k]      = FP'(src_samp[k]);
      dir[k]       = fvec[k][node_ent[k][FW-1:0]] ^ node_ent[k][FW];
      nxt_p[k]     = (src_p[k] << 1) | DEPTH'(dir[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      p_q    <= '0;
      outp_q <= '0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= src_vld[k];
          if (src_vld[k]) p_q[k] <= nxt_p[k];
        end
      end
      if (rdy[DEPTH-1] && src_vld[DEPTH-1]) begin
        outp_q <= leaf_q[nxt_p[DEPTH-1]];
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld_q[DEPTH-1];
  assign bus.out_leaf  = p_q[DEPTH-1];
  assign bus.outp      = outp_q;
endmodule
